// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller around the ID/EXE register: load-use stall, taken-branch flush, dmem-wait freeze.
// Optional HAZARD_PERF_EN adds saturating stall/flush/freeze performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_memRd,
    input  logic             ex_regWr,
    input  logic [2:0]       ex_rd,
    input  logic             br_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_cycles
`endif
);

    localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       hit;
    logic       freeze;

    if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: LOAD_LAT must be 1..7 and CNT_W >= 1");
    end

    assign hit = ex_memRd & ex_regWr &
                 ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));
    assign freeze = mem_access & ~dmem_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state and pipeline controls, highest priority event first
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_nx = RUN;
            cnt_nx   = 3'd0;
        end else if (freeze) begin
            // Whole pipe holds; a branch in EXE is seen again once memory releases
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nx    = RUN;
            cnt_nx      = 3'd0;
        end else if (state == LDSTALL) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            cnt_nx      = cnt - 3'd1;
            if (cnt == 3'd1) begin
                state_nx = RUN;
            end
        end else if (hit) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nx = LDSTALL;
                cnt_nx   = CNT_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;
    logic freeze_inc;

    assign stall_inc  = idex_bubble & ~ifid_flush;
    assign flush_inc  = br_taken & ~freeze;
    assign freeze_inc = freeze;

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            freeze_cycles <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (freeze_inc && (freeze_cycles != '1)) begin
                freeze_cycles <= freeze_cycles + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
// Build with HAZARD_PERF_EN to also check the counters (CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic       clk;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_memRd, ex_regWr;
    logic       br_taken, mem_access, dmem_ready;

    logic pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, memwb_bubble1;
    logic pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_en3, memwb_bubble3;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall1, flush1, frz1, stall3, flush3, frz3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  q_exp1[$];
    logic [6:0]  q_exp3[$];
    logic [11:0] q_perf[$];
    int rem1 = 0;
    int rem3 = 0;
    int p_stall = 0;
    int p_flush = 0;
    int p_frz   = 0;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memRd(ex_memRd), .ex_regWr(ex_regWr), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
        .idex_en(idex_en1), .idex_bubble(idex_bubble1), .exmem_en(exmem_en1),
        .memwb_bubble(memwb_bubble1)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall1), .flush_count(flush1), .freeze_cycles(frz1)
`endif
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memRd(ex_memRd), .ex_regWr(ex_regWr), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3),
        .idex_en(idex_en3), .idex_bubble(idex_bubble3), .exmem_en(exmem_en3),
        .memwb_bubble(memwb_bubble3)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall3), .flush_count(flush3), .freeze_cycles(frz3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: bit order {pc_en,ifid_en,ifid_flush,idex_en,idex_bubble,exmem_en,memwb_bubble}
    function automatic logic [6:0] model(input int lat, input int rem, output int rem_nx,
                                         input logic r, input logic h, input logic frz,
                                         input logic br);
        rem_nx = rem;
        if (r) begin
            rem_nx = 0;
            return 7'b0000000;
        end
        if (frz) return 7'b0000001;
        if (br) begin
            rem_nx = 0;
            return 7'b1111110;
        end
        if (rem > 0) begin
            rem_nx = rem - 1;
            return 7'b0001110;
        end
        if (h) begin
            rem_nx = lat - 1;
            return 7'b0001110;
        end
        return 7'b1101010;
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    // One clock: drive after posedge, push expectations, compare at negedge
    task automatic cyc(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic mrd, input logic rwr,
                       input logic [2:0] rd, input logic br, input logic macc,
                       input logic rdy, input string tag);
        logic       h, frz;
        logic [6:0] e1, e3, g1, g3;
        logic [11:0] ep;
        int         nx;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_memRd = mrd; ex_regWr = rwr; ex_rd = rd;
        br_taken = br; mem_access = macc; dmem_ready = rdy;

        h   = mrd & rwr & ((urs & (rd == rs)) | (urt & (rd == rt)));
        frz = macc & ~rdy;
        e1 = model(1, rem1, nx, r, h, frz, br); rem1 = nx;
        e3 = model(3, rem3, nx, r, h, frz, br); rem3 = nx;
        q_exp1.push_back(e1);
        q_exp3.push_back(e3);
        if (r) begin
            p_stall = 0; p_flush = 0; p_frz = 0;
        end
        ep = {4'(p_stall), 4'(p_flush), 4'(p_frz)};
        q_perf.push_back(ep);
        if (!r) begin
            if (e3[2] && !e3[4]) p_stall = sat(p_stall);
            if (br && !frz)      p_flush = sat(p_flush);
            if (frz)             p_frz   = sat(p_frz);
        end

        @(negedge clk);
        g1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, memwb_bubble1};
        g3 = {pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_en3, memwb_bubble3};
        check({tag, "/lat1"}, 16'(g1), 16'(q_exp1.pop_front()));
        check({tag, "/lat3"}, 16'(g3), 16'(q_exp3.pop_front()));
        ep = q_perf.pop_front();
`ifdef HAZARD_PERF_EN
        check({tag, "/perf"}, 16'({stall3, flush3, frz3}), 16'(ep));
`endif
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 0; id_use_rt = 0; ex_memRd = 0; ex_regWr = 0;
        br_taken = 0; mem_access = 0; dmem_ready = 1;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
        cyc(1, 3, 3, 1, 1, 1, 1, 3, 1, 1, 0, "reset_busy");
        idle(2, "idle");

        // Load r3 in EXE, ID reads rs=r3; the load leaves EXE after one cycle
        cyc(0, 3, 1, 1, 0, 1, 1, 3, 0, 0, 1, "ldu_rs");
        idle(4, "ldu_after");

        // rt match, and the near-misses that must not stall
        cyc(0, 2, 5, 0, 1, 1, 1, 5, 0, 0, 1, "ldu_rt");
        idle(3, "ldu_rt_after");
        cyc(0, 2, 5, 0, 0, 1, 1, 5, 0, 0, 1, "no_use");
        cyc(0, 5, 5, 1, 1, 1, 0, 5, 0, 0, 1, "no_regwr");
        cyc(0, 5, 5, 1, 1, 0, 1, 5, 0, 0, 1, "no_memrd");
        cyc(0, 4, 6, 1, 1, 1, 1, 7, 0, 0, 1, "rd_diff");

        // Branch coincident with hit wins, no stall follows
        cyc(0, 3, 0, 1, 0, 1, 1, 3, 1, 0, 1, "br_hit");
        idle(2, "br_hit_after");

        // Branch aborts a stall in progress
        cyc(0, 3, 0, 1, 0, 1, 1, 3, 0, 0, 1, "ld_then_br");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "br_abort");
        idle(2, "br_abort_after");

        // Freeze for 4 cycles with cnt=2, branch ignored while frozen
        cyc(0, 3, 0, 1, 0, 1, 1, 3, 0, 0, 1, "ld_frz");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "frz");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "frz_br");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "frz");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "frz");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "frz_release");
        idle(3, "frz_after");

        // Reset in the middle of a stall
        cyc(0, 3, 0, 1, 0, 1, 1, 3, 0, 0, 1, "ld_rst");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_mid");
        idle(3, "rst_after");

        // Long freeze saturates a narrow counter; two branches
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "frz20");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "br1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "br2");
        idle(2, "perf_after");

        // Random mix
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 39) == 0), 3'($urandom), 3'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
                "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
